// File: rtl/mac_result_buffer.sv
// Warm-up discard, Q-format rescale and FWFT FIFO for the unrolled MAC result stream.
// Optional clamp-to-range on rescale is enabled by defining MAC_OUT_SAT_EN.
module mac_result_buffer #(
    parameter int DATA_W      = 32,
    parameter int OUT_W       = 16,
    parameter int SHIFT       = 15,
    parameter int FILL_CYCLES = 16,
    parameter int DEPTH       = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     fill_done,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     sat_seen
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;

    // state    | meaning
    // ST_FILL  | delay line filling, samples counted and discarded
    // ST_RUN   | samples rescaled and buffered until reset
    typedef enum logic {ST_FILL, ST_RUN} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [LVL_W-1:0]   level_q;
    logic               fill_done_q;
    logic               overflow_q;
    logic [OUT_W-1:0]   mem_q [DEPTH];
    logic [OUT_W-1:0]   scaled_d;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;

`ifdef MAC_OUT_SAT_EN
    localparam logic signed [DATA_W-1:0] SAT_MAX =
        $signed({{(DATA_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [DATA_W-1:0] SAT_MIN =
        $signed({{(DATA_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

    logic signed [DATA_W-1:0] shifted;
    logic                     clamp_d;
    logic                     sat_q;

    assign shifted = $signed(in_data) >>> SHIFT;

    always_comb begin
        clamp_d  = 1'b0;
        scaled_d = shifted[OUT_W-1:0];
        if (shifted > SAT_MAX) begin
            clamp_d  = 1'b1;
            scaled_d = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            clamp_d  = 1'b1;
            scaled_d = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            sat_q <= 1'b0;
        else if (state_q == ST_RUN && in_valid && clamp_d)
            sat_q <= 1'b1;
    end

    assign sat_seen = sat_q;
`else
    assign scaled_d = OUT_W'($signed(in_data) >>> SHIFT);
    assign sat_seen = 1'b0;
`endif

    assign out_valid = (level_q != '0);
    assign full      = (level_q == LVL_W'(DEPTH));
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign push      = (state_q == ST_RUN) && in_valid && (!full || pop);
    assign drop      = (state_q == ST_RUN) && in_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FILL;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            fill_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (FILL_CYCLES == 0) begin
                        state_q     <= ST_RUN;
                        fill_done_q <= 1'b1;
                    end else if (in_valid) begin
                        if (cnt_q == CNT_W'(FILL_CYCLES - 1)) begin
                            state_q     <= ST_RUN;
                            fill_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_RUN;
            endcase

            if (push) begin
                mem_q[wr_ptr_q] <= scaled_d;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)
                level_q <= level_q + 1'b1;
            else if (pop && !push)
                level_q <= level_q - 1'b1;
            if (drop)
                overflow_q <= 1'b1;
        end
    end

    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign fill_done = fill_done_q;
    assign level     = level_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_mac_result_buffer.sv
// Randomized scoreboard bench for mac_result_buffer with directed warm-up, range,
// backpressure and mid-run reset sequences.
module tb_mac_result_buffer;

    localparam int DATA_W = 32;
    localparam int OUT_W  = 16;
    localparam int SHIFT  = 4;
    localparam int FILL   = 16;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [OUT_W-1:0]  out_data;
    logic              fill_done;
    logic [3:0]        level;
    logic              overflow;
    logic              sat_seen;

    mac_result_buffer #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .SHIFT(SHIFT),
        .FILL_CYCLES(FILL), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fill_done(fill_done), .level(level), .overflow(overflow),
        .sat_seen(sat_seen)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: expected FIFO contents and flags.
    logic [15:0] exp_q[$];
    int          fill_cnt;
    bit          run_m;
    bit          ovf_m;
    bit          sat_m;
    bit          mon_popped;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_scale(input logic [31:0] d, output bit clamped);
        longint      v;
        logic [63:0] b;
        v = longint'($signed(d));
        v = v >>> SHIFT;
        clamped = 1'b0;
`ifdef MAC_OUT_SAT_EN
        if (v > 32767) begin
            v = 32767;
            clamped = 1'b1;
        end else if (v < -32768) begin
            v = -32768;
            clamped = 1'b1;
        end
`endif
        b = v;
        return b[15:0];
    endfunction

    always @(posedge clk) begin
        bit          clamped;
        logic [15:0] s;
        int          occ;
        bit          pop;
        if (reset) begin
            exp_q.delete();
            fill_cnt   = 0;
            run_m      = 1'b0;
            ovf_m      = 1'b0;
            sat_m      = 1'b0;
            mon_popped = 1'b0;
        end else begin
            pop        = mon_popped;
            mon_popped = 1'b0;
            occ        = exp_q.size() + (pop ? 1 : 0);
            if (run_m && in_valid) begin
                s = ref_scale(in_data, clamped);
                if (clamped) sat_m = 1'b1;
                if (occ < DEPTH || pop) exp_q.push_back(s);
                else ovf_m = 1'b1;
            end else if (!run_m && in_valid) begin
                fill_cnt++;
                if (fill_cnt == FILL) run_m = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
            chk("level", {28'b0, level}, exp_q.size());
            chk("fill_done", {31'b0, fill_done}, {31'b0, run_m});
            chk("overflow", {31'b0, overflow}, {31'b0, ovf_m});
            chk("sat_seen", {31'b0, sat_seen}, {31'b0, sat_m});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_empty: got out_data %0h expected no data at %0t", out_data, $time);
                end else begin
                    chk("out_data", {16'b0, out_data}, {16'b0, exp_q[0]});
                    void'(exp_q.pop_front());
                    mon_popped = 1'b1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cyc();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 'hFFFFF));
            2:       return 32'hFFFF_0000 | 32'($urandom_range(0, 'hFFFF));
            default: return 32'hFFF0_0000 | 32'($urandom_range(0, 'hFFFFF));
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        repeat (3) cyc();
        chk("rst_level", {28'b0, level}, 0);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out_data", {16'b0, out_data}, 0);
        chk("rst_fill_done", {31'b0, fill_done}, 0);
        chk("rst_overflow", {31'b0, overflow}, 0);
        reset     = 1'b0;
        out_ready = 1'b1;

        for (int i = 0; i < FILL; i++) begin
            push(32'h0000_0100);
            chk("warm_out_valid", {31'b0, out_valid}, 0);
            chk("warm_fill_done", {31'b0, fill_done}, (i == FILL - 1) ? 1 : 0);
        end
        push(32'h0000_0170);
        chk("first_valid", {31'b0, out_valid}, 1);
        chk("first_data", {16'b0, out_data}, 32'h0017);
        cyc();

        push(32'hFFFF_FF00);
        chk("neg_data", {16'b0, out_data}, 32'hFFF0);
        chk("neg_sat", {31'b0, sat_seen}, 0);
        cyc();

        push(32'h0010_0000);
`ifdef MAC_OUT_SAT_EN
        chk("range_data", {16'b0, out_data}, 32'h7FFF);
        chk("range_sat", {31'b0, sat_seen}, 1);
        cyc();
        push(32'h8000_0000);
        chk("min_data", {16'b0, out_data}, 32'h8000);
`else
        chk("range_data", {16'b0, out_data}, 32'h0000);
        chk("range_sat", {31'b0, sat_seen}, 0);
`endif
        cyc();

        out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) push(32'(i * 16));
        chk("full_level", {28'b0, level}, 8);
        chk("full_overflow", {31'b0, overflow}, 1);
        chk("full_head", {16'b0, out_data}, 1);
        in_valid  = 1'b1;
        in_data   = 32'h0000_0500;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("simul_level", {28'b0, level}, 8);
        chk("simul_head", {16'b0, out_data}, 2);
        repeat (9) cyc();
        chk("drain_level", {28'b0, level}, 0);
        chk("drain_valid", {31'b0, out_valid}, 0);
        chk("drain_overflow", {31'b0, overflow}, 1);

        out_ready = 1'b0;
        repeat (5) push(rand_data());
        chk("pre_rst_level", {28'b0, level}, 5);
        reset = 1'b1;
        cyc();
        chk("mid_rst_level", {28'b0, level}, 0);
        chk("mid_rst_valid", {31'b0, out_valid}, 0);
        chk("mid_rst_fill", {31'b0, fill_done}, 0);
        chk("mid_rst_ovf", {31'b0, overflow}, 0);
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (FILL) push(rand_data());
        chk("refill_level", {28'b0, level}, 0);
        chk("refill_done", {31'b0, fill_done}, 1);

        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = rand_data();
            out_ready = ((i / 300) % 2 == 1) ? ($urandom_range(0, 3) == 0)
                                             : ($urandom_range(0, 3) != 0);
            cyc();
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) cyc();
        chk("final_level", {28'b0, level}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
